// File: rtl/alu_mc.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// One operation in flight; valid/ready handshakes on operand and result sides.
module alu_mc #(
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned OPCODE_SIZE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_SIZE-1:0]   data_a,
    input  logic [DATA_SIZE-1:0]   data_b,
    input  logic [OPCODE_SIZE-1:0] opcode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_SIZE-1:0]   out,
    output logic [DATA_SIZE-1:0]   out_hi,
    output logic                   carry,
    output logic                   zero,
    output logic                   div_zero
);
    localparam int unsigned CW = $clog2(DATA_SIZE);

    localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(0);
    localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(1);
    localparam logic [OPCODE_SIZE-1:0] OP_MUL = OPCODE_SIZE'(2);
    localparam logic [OPCODE_SIZE-1:0] OP_DIV = OPCODE_SIZE'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic                 op_div;
    logic [DATA_SIZE-1:0] opnd;
    logic [DATA_SIZE-1:0] work_hi;
    logic [DATA_SIZE-1:0] work_lo;
    logic [CW-1:0]        cnt;

    logic [DATA_SIZE:0]   add_sum;
    logic [DATA_SIZE-1:0] sub_diff;
    logic [DATA_SIZE:0]   mul_sum;
    logic [DATA_SIZE:0]   div_rs;
    logic [DATA_SIZE:0]   div_rem;
    logic                 div_ge;
    logic [DATA_SIZE-1:0] step_hi;
    logic [DATA_SIZE-1:0] step_lo;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Single-cycle ops plus one iteration of the multiply/divide datapath.
    // MUL: {work_hi,work_lo} holds {partial product, remaining multiplier bits}.
    // DIV: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
    always_comb begin
        add_sum  = {1'b0, data_a} + {1'b0, data_b};
        sub_diff = data_a - data_b;
        mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        div_rs   = {work_hi, work_lo[DATA_SIZE-1]};
        div_ge   = (div_rs >= {1'b0, opnd});
        div_rem  = div_ge ? (div_rs - {1'b0, opnd}) : div_rs;
        if (op_div) begin
            step_hi = div_rem[DATA_SIZE-1:0];
            step_lo = {work_lo[DATA_SIZE-2:0], div_ge};
        end else begin
            step_hi = mul_sum[DATA_SIZE:1];
            step_lo = {mul_sum[0], work_lo[DATA_SIZE-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_div   <= 1'b0;
            opnd     <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            cnt      <= '0;
            out      <= '0;
            out_hi   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        case (opcode)
                            OP_SUB: begin
                                out      <= sub_diff;
                                out_hi   <= '0;
                                carry    <= (data_a < data_b);
                                zero     <= (sub_diff == '0);
                                div_zero <= 1'b0;
                                state    <= S_DONE;
                            end
                            OP_MUL: begin
                                op_div  <= 1'b0;
                                opnd    <= data_a;
                                work_hi <= '0;
                                work_lo <= data_b;
                                cnt     <= CW'(DATA_SIZE - 1);
                                state   <= S_BUSY;
                            end
                            OP_DIV: begin
                                if (data_b == '0) begin
                                    out      <= '1;
                                    out_hi   <= data_a;
                                    carry    <= 1'b0;
                                    zero     <= 1'b0;
                                    div_zero <= 1'b1;
                                    state    <= S_DONE;
                                end else begin
                                    op_div  <= 1'b1;
                                    opnd    <= data_b;
                                    work_hi <= '0;
                                    work_lo <= data_a;
                                    cnt     <= CW'(DATA_SIZE - 1);
                                    state   <= S_BUSY;
                                end
                            end
                            default: begin
                                // OP_ADD and any undefined opcode
                                out      <= add_sum[DATA_SIZE-1:0];
                                out_hi   <= '0;
                                carry    <= add_sum[DATA_SIZE];
                                zero     <= (add_sum[DATA_SIZE-1:0] == '0);
                                div_zero <= 1'b0;
                                state    <= S_DONE;
                            end
                        endcase
                    end
                end
                S_BUSY: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt - CW'(1);
                    if (cnt == '0) begin
                        out      <= step_lo;
                        out_hi   <= step_hi;
                        carry    <= 1'b0;
                        zero     <= (step_lo == '0);
                        div_zero <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (DATA_SIZE=8): directed cases, backpressure, async reset mid-op,
// then random operations checked against an arithmetic reference model.
module tb_alu_mc;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [1:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         carry;
    logic         zero;
    logic         div_zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_mc #(.DATA_SIZE(W), .OPCODE_SIZE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .carry     (carry),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic void model(input int op, input int a, input int b,
                                  output int o, output int hi, output int c,
                                  output int z, output int dz, output int lat);
        int s;
        o = 0; hi = 0; c = 0; dz = 0; lat = 1;
        case (op)
            0: begin s = a + b; o = s % 256; c = s / 256; end
            1: begin o = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: begin s = a * b; o = s % 256; hi = s / 256; lat = W + 1; end
            default: begin
                if (b == 0) begin o = 255; hi = a; dz = 1; end
                else begin o = a / b; hi = a % b; lat = W + 1; end
            end
        endcase
        z = (o == 0) ? 1 : 0;
    endfunction

    // Issue one op, measure latency, hold the result for 'hold' cycles with junk
    // in_valid pulses, then complete the handshake.
    task automatic do_op(input int op, input int a, input int b, input int hold);
        int eo, ehi, ec, ez, edz, elat, lat;
        bit ready_seen;
        model(op, a, b, eo, ehi, ec, ez, edz, elat);
        @(negedge clk);
        chk("in_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        opcode   = 2'(op);
        data_a   = 8'(a);
        data_b   = 8'(b);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        lat        = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("busy_in_ready", 32'(ready_seen), 32'd0);
        for (int i = 0; i <= hold; i++) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("in_ready_done", 32'(in_ready), 32'd0);
            chk("out", 32'(out), 32'(eo));
            chk("out_hi", 32'(out_hi), 32'(ehi));
            chk("carry", 32'(carry), 32'(ec));
            chk("zero", 32'(zero), 32'(ez));
            chk("div_zero", 32'(div_zero), 32'(edz));
            if (i < hold) begin
                @(negedge clk);
                in_valid = 1'b1;
                opcode   = 2'($urandom_range(0, 3));
                data_a   = 8'($urandom);
                data_b   = 8'($urandom);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 2'd0;
        data_a    = '0;
        data_b    = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_hi", 32'(out_hi), 32'd0);
        chk("rst_flags", 32'({carry, zero, div_zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        do_op(0, 200, 100, 0);
        do_op(1, 5, 7, 0);
        do_op(1, 9, 9, 0);
        do_op(2, 255, 255, 0);
        do_op(3, 100, 7, 0);
        do_op(3, 37, 0, 0);
        do_op(3, 0, 5, 0);
        do_op(3, 255, 1, 0);
        do_op(2, 0, 200, 0);
        do_op(2, 13, 11, 5);
        do_op(0, 3, 4, 0);

        // Async reset in the middle of a MUL.
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 2'd2;
        data_a   = 8'd255;
        data_b   = 8'd255;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out", 32'(out), 32'd0);
        chk("mid_rst_out_hi", 32'(out_hi), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            chk("no_result_after_rst", 32'(out_valid), 32'd0);
        end
        do_op(0, 1, 1, 0);

        for (int k = 0; k < 60; k++) begin
            int op, a, b;
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
